// File: rtl/rv_pkg.sv
// Shared RV32 pipeline types and constants.
// Holds the fetch-entry bundle passed from fetch to decode.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            oor;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Word index compared against memory size in words.
    function automatic logic in_range(
        input logic [XLEN-3:0] word,
        input int unsigned     words
    );
        return {2'b00, word} < words;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO buffering fetched entries for decode.
// Flush empties it in one cycle and wins over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 65,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, run/halt FSM,
// out-of-range substitution and redirect flushing.
module fetch_controller
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_oor,
    output logic        halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;
    fetch_entry_t     wentry;
    fetch_entry_t     head;
    logic             pop;
    logic             push;
    logic             oor;

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);
    assign if_valid  = ~fifo_empty;
    assign pop       = if_valid & if_ready;

    assign push = (state_q == RUN) & ~halt_req & ~redirect_valid
                & ((fifo_count < DEPTH_C) | pop);

    assign oor = ~in_range(pc_q[31:2], MEM_WORDS);

    always_comb begin
        wentry       = '0;
        wentry.pc    = pc_q;
        wentry.oor   = oor;
        wentry.instr = oor ? NOP_INSTR : imem_rdata;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:  if (halt_req && !redirect_valid) state_d = HALT;
            HALT: if (redirect_valid) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect targets are word aligned; low bits are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc & ~32'h3;
        end else if (push) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop & ~redirect_valid),
        .wdata (wentry),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_comb begin
        head     = fetch_entry_t'(fifo_rdata);
        if_instr = if_valid ? head.instr : 32'h0;
        if_pc    = if_valid ? head.pc    : 32'h0;
        if_oor   = if_valid & head.oor;
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller.
// Expected entries are queued when a fetch is predicted, popped on handoff.
module tb_fetch_controller;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_oor;
    logic        halted;

    always #5 clk = ~clk;

    fetch_controller #(
        .RESET_PC  (32'h0),
        .DEPTH     (2),
        .MEM_WORDS (1024),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_oor         (if_oor),
        .halted         (halted)
    );

    logic [31:0] mem [0:1023];

    assign imem_rdata = (imem_addr < 32'h1000) ? mem[imem_addr[11:2]]
                                               : 32'hDEAD_BEEF;

    int nerr = 0;
    int nchk = 0;

    fetch_entry_t sb[$];
    logic [31:0]  mpc;
    logic         mhalt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance the reference model one edge.
    task automatic step();
        fetch_entry_t e;
        logic pop;
        logic push;
        @(negedge clk);
        chk("valid", {31'b0, if_valid}, {31'b0, sb.size() > 0});
        chk("addr", imem_addr, mpc);
        chk("halted", {31'b0, halted}, {31'b0, mhalt});
        if (sb.size() > 0) begin
            chk("pc", if_pc, sb[0].pc);
            chk("instr", if_instr, sb[0].instr);
            chk("oor", {31'b0, if_oor}, {31'b0, sb[0].oor});
        end else begin
            chk("pc0", if_pc, 32'h0);
            chk("instr0", if_instr, 32'h0);
            chk("oor0", {31'b0, if_oor}, 32'h0);
        end
        pop = (sb.size() > 0) && if_ready;
        if (reset) begin
            sb.delete();
            mpc   = 32'h0;
            mhalt = 1'b0;
        end else if (redirect_valid) begin
            sb.delete();
            mpc   = redirect_pc & ~32'h3;
            mhalt = 1'b0;
        end else begin
            push = !mhalt && !halt_req && (sb.size() < 2 || pop);
            if (pop) void'(sb.pop_front());
            if (push) begin
                e.pc    = mpc;
                e.oor   = (mpc >= 32'h1000);
                e.instr = e.oor ? 32'h13 : mem[mpc[11:2]];
                sb.push_back(e);
                mpc = mpc + 32'd4;
            end
            if (halt_req) mhalt = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        if_ready       = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        sb.delete();
        mpc   = 32'h0;
        mhalt = 1'b0;
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        reset = 1'b0;

        // backpressure from the first valid entry
        steps(6);
        chk("bp_addr", imem_addr, 32'h8);
        chk("bp_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        steps(12);

        // redirect while full
        if_ready = 1'b0;
        steps(3);
        redirect_to(32'h43);
        chk("rd_valid", {31'b0, if_valid}, 32'h0);
        chk("rd_addr", imem_addr, 32'h40);
        step();
        chk("rd_pc", if_pc, 32'h40);
        if_ready = 1'b1;
        steps(4);

        // halt with two buffered entries at pc 0x10
        if_ready = 1'b0;
        redirect_to(32'h8);
        steps(2);
        chk("h_addr0", imem_addr, 32'h10);
        halt_req = 1'b1;
        step();
        chk("h_halted", {31'b0, halted}, 32'h1);
        if_ready = 1'b1;
        steps(4);
        chk("h_drained", {31'b0, if_valid}, 32'h0);
        chk("h_addr", imem_addr, 32'h10);
        halt_req = 1'b0;
        redirect_to(32'h20);
        chk("h_resume", {31'b0, halted}, 32'h0);
        step();
        chk("h_pc", if_pc, 32'h20);
        steps(3);

        // out-of-range boundary
        redirect_to(32'hFFC);
        step();
        chk("oor_last_pc", if_pc, 32'hFFC);
        chk("oor_last", {31'b0, if_oor}, 32'h0);
        step();
        chk("oor_pc", if_pc, 32'h1000);
        chk("oor_instr", if_instr, 32'h13);
        chk("oor_flag", {31'b0, if_oor}, 32'h1);
        steps(3);

        // reset while full with pop active
        if_ready = 1'b0;
        steps(3);
        if_ready = 1'b1;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_valid", {31'b0, if_valid}, 32'h0);
        chk("mr_addr", imem_addr, 32'h0);
        steps(8);

        // random mix
        for (int i = 0; i < 400; i++) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            halt_req       = ($urandom_range(0, 15) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom_range(0, 1) ?
                             32'($urandom_range(0, 255))
                           : 32'($urandom_range(32'hFE0, 32'h1020));
            step();
        end
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        steps(4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
